pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 64, width of the payload carried through the stage (operands, immediates, PC+4, register addresses).
REQ-002 Parameter CTRL_W, default 8, width of the control-signal bundle, which is forced to zero whenever the stage holds no valid entry.
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset; 0 sampled at a rising edge of clk resets the block.
REQ-006 Port in_valid  input  1  upstream entry present.
REQ-007 Port in_ready  output  1  block can accept an entry this cycle.
REQ-008 Port in_ctrl  input  CTRL_W  upstream control bundle.
REQ-009 Port in_data  input  DATA_W  upstream payload.
REQ-010 Port out_valid  output  1  head entry present.
REQ-011 Port out_ready  input  1  downstream consumes the head entry this cycle.
REQ-012 Port out_ctrl  output  CTRL_W  head control bundle; all zero when out_valid=0.
REQ-013 Port out_data  output  DATA_W  head payload; all zero when out_valid=0.
REQ-014 Port flush  input  1  discard all held entries (branch redirect).
REQ-015 Port stall_cnt  output  CNT_W  saturating count of stalled cycles.
REQ-016 Port flush_cnt  output  CNT_W  saturating count of flushes that discarded at least one entry.

Function
REQ-017 The block SHALL be a two-entry skid buffer with states EMPTY, ONE and FULL, holding a head register and a skid register, each of width CTRL_W+DATA_W.
REQ-018 Accept SHALL be defined as in_valid & in_ready & !flush, and deliver SHALL be defined as out_valid & out_ready & !flush.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, and SHALL be driven from state only, with no combinational path from out_ready.
REQ-020 out_valid SHALL be 1 in ONE and FULL, and out_ctrl/out_data SHALL present the head register.
REQ-021 State transitions: EMPTY+accept->ONE; ONE+accept+deliver->ONE with new entry in head; ONE+accept only->FULL with new entry in skid; ONE+deliver only->EMPTY; FULL+deliver->ONE with skid moved to head; all other cases hold state.
REQ-022 Latency from accept in EMPTY to out_valid=1 SHALL be exactly one cycle; entries SHALL leave in acceptance order with no loss or duplication.
REQ-023 flush=1 SHALL force the next state to EMPTY regardless of in_valid or out_ready, and no entry is accepted or delivered in that cycle.
REQ-024 In the cycle after a flush, out_valid=0, out_ctrl=0, out_data=0, and in_ready=1.
REQ-025 stall_cnt SHALL increment by 1 in each cycle with out_valid=1, out_ready=0 and flush=0, and SHALL saturate at 2^CNT_W-1.
REQ-026 flush_cnt SHALL increment by 1 in each cycle with flush=1 and state not EMPTY, and SHALL saturate at 2^CNT_W-1.
REQ-027 Inputs presented while in_ready=0 SHALL be ignored and SHALL not corrupt held entries.

Reset
REQ-028 While reset=0 at a clock edge, state SHALL become EMPTY and both counters SHALL become 0, so the next cycle shows out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0, flush_cnt=0.
REQ-029 Reset SHALL take priority over flush and over any accept or deliver in the same cycle, and SHALL discard held entries mid-operation.

Verification
REQ-030 Stream: out_ready=1, accept A=0x11, B=0x22, C=0x33 on back-to-back cycles -> out_data is 0x11, 0x22, 0x33 on the following three cycles, and in_ready stays 1.
REQ-031 Backpressure: out_ready=0, offer A, B, C -> A and B are accepted, in_ready=0 from the cycle after B, C is held off, and stall_cnt counts each stalled cycle; then out_ready=1 -> A, B, C are delivered in order.
REQ-032 Flush: block FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, flush_cnt=1, and the offered entry is not accepted.
REQ-033 Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15.
REQ-034 Reset mid-operation: block FULL, reset=0 for one cycle -> all outputs are at their reset values, and the old entries never appear at the output.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
// Two-entry skid buffer used between pipeline stages. The head register
// drives the outputs. The skid register catches the one extra entry that
// arrives while the head is stalled. Because in_ready depends only on the
// registered state, no combinational path runs from out_ready back upstream.
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   reset      - synchronous, active-low reset
//   in_valid   - upstream entry present
//   in_ready   - buffer can take an entry this cycle (EMPTY or ONE)
//   in_ctrl    - upstream control bundle
//   in_data    - upstream payload
//   out_valid  - head entry present (ONE or FULL)
//   out_ready  - downstream consumes the head entry this cycle
//   out_ctrl   - head control bundle, zero when out_valid=0
//   out_data   - head payload, zero when out_valid=0
//   flush      - discard everything held (branch redirect)
//   stall_cnt  - saturating count of cycles with a stalled head entry
//   flush_cnt  - saturating count of flushes that discarded something
module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_nextState;
    logic [CTRL_W-1:0] r_headCtrl;
    logic [DATA_W-1:0] r_headData;
    logic [CTRL_W-1:0] r_skidCtrl;
    logic [DATA_W-1:0] r_skidData;
    logic [CNT_W-1:0]  r_stallCnt;
    logic [CNT_W-1:0]  r_flushCnt;

    logic w_accept;
    logic w_deliver;
    logic w_headFromIn;
    logic w_headFromSkid;
    logic w_skidFromIn;
    logic w_stallInc;
    logic w_flushInc;

    // Handshake qualifiers. A flush cancels both sides of the transfer, so
    // nothing is accepted or delivered during a flush cycle.
    always_comb begin
        in_ready       = (r_state != FULL);
        out_valid      = (r_state != EMPTY);
        w_accept       = in_valid & in_ready & ~flush;
        w_deliver      = out_valid & out_ready & ~flush;
        w_headFromIn   = w_accept & ((r_state == EMPTY) | ((r_state == ONE) & w_deliver));
        w_headFromSkid = w_deliver & (r_state == FULL);
        w_skidFromIn   = w_accept & (r_state == ONE) & ~w_deliver;
        w_stallInc     = out_valid & ~out_ready & ~flush;
        w_flushInc     = flush & (r_state != EMPTY);
    end

    // Next-state logic. Flush overrides every other transition and empties
    // the buffer.
    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: if (w_accept) w_nextState = ONE;
                ONE: begin
                    if (w_accept && !w_deliver) w_nextState = FULL;
                    else if (!w_accept && w_deliver) w_nextState = EMPTY;
                end
                FULL: if (w_deliver) w_nextState = ONE;
                default: w_nextState = EMPTY;
            endcase
        end
    end

    // State and counters. Reset wins over flush and over any transfer.
    // Each counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= EMPTY;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_stallInc && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + CntOne;
            if (w_flushInc && (r_flushCnt != '1)) r_flushCnt <= r_flushCnt + CntOne;
        end
    end

    // Entry storage. These registers are not reset, because outputs are
    // masked by out_valid and stale contents can never reach them.
    always_ff @(posedge clk) begin
        if (w_headFromIn) begin
            r_headCtrl <= in_ctrl;
            r_headData <= in_data;
        end else if (w_headFromSkid) begin
            r_headCtrl <= r_skidCtrl;
            r_headData <= r_skidData;
        end
        if (w_skidFromIn) begin
            r_skidCtrl <= in_ctrl;
            r_skidData <= in_data;
        end
    end

    // Output presentation. The bundle is zeroed whenever the buffer holds
    // no valid entry.
    always_comb begin
        out_ctrl  = out_valid ? r_headCtrl : '0;
        out_data  = out_valid ? r_headData : '0;
        stall_cnt = r_stallCnt;
        flush_cnt = r_flushCnt;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf
// Directed, table-driven bench for pipe_stage_buf. It covers streaming,
// backpressure, flush, and reset in the middle of operation. A second
// instance with 4-bit counters shares the same inputs and is used to show
// that the stall counter saturates.
module tb_pipe_stage_buf;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic [7:0]  inCtrl;
    logic [63:0] inData;
    logic        outReady;
    logic        flush;

    logic        inReady,  inReadyS;
    logic        outValid, outValidS;
    logic [7:0]  outCtrl,  outCtrlS;
    logic [63:0] outData,  outDataS;
    logic [15:0] stallCnt, flushCnt;
    logic [3:0]  stallCntS, flushCntS;

    int checks;
    int errors;

    typedef struct {
        logic        rstN;
        logic        inValid;
        logic [63:0] inData;
        logic [7:0]  inCtrl;
        logic        outReady;
        logic        flush;
        logic        expValid;
        logic [63:0] expData;
        logic [7:0]  expCtrl;
        logic        expInReady;
        logic [15:0] expStall;
        logic [15:0] expFlush;
    } vec_t;

    localparam int NumVecs = 25;
    vec_t vecs [NumVecs];

    pipe_stage_buf #(.DATA_W(64), .CTRL_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(inValid), .in_ready(inReady), .in_ctrl(inCtrl), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_ctrl(outCtrl), .out_data(outData),
        .flush(flush), .stall_cnt(stallCnt), .flush_cnt(flushCnt)
    );

    pipe_stage_buf #(.DATA_W(64), .CTRL_W(8), .CNT_W(4)) dutSat (
        .clk(clk), .reset(reset),
        .in_valid(inValid), .in_ready(inReadyS), .in_ctrl(inCtrl), .in_data(inData),
        .out_valid(outValidS), .out_ready(outReady), .out_ctrl(outCtrlS), .out_data(outDataS),
        .flush(flush), .stall_cnt(stallCntS), .flush_cnt(flushCntS)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(
        input logic rstN, input logic iv, input logic [63:0] d, input logic [7:0] c,
        input logic ordy, input logic fl,
        input logic ev, input logic [63:0] ed, input logic [7:0] ec,
        input logic eir, input logic [15:0] es, input logic [15:0] ef);
        vec_t v;
        v.rstN = rstN; v.inValid = iv; v.inData = d; v.inCtrl = c;
        v.outReady = ordy; v.flush = fl;
        v.expValid = ev; v.expData = ed; v.expCtrl = ec;
        v.expInReady = eir; v.expStall = es; v.expFlush = ef;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, and then settle just
    // after the edge so that registered outputs can be sampled.
    task automatic applyStimulus(input logic rstN, input logic iv, input logic [63:0] d,
                                 input logic [7:0] c, input logic ordy, input logic fl);
        reset    = rstN;
        inValid  = iv;
        inData   = d;
        inCtrl   = c;
        outReady = ordy;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inCtrl   = '0;
        outReady = 1'b0;
        flush    = 1'b0;

        //                 rst iv data    ctrl   ordy fl | ev  data    ctrl   ir  stall flush
        // Reset, then stream A/B/C straight through.
        vecs[0]  = mkVec(0, 0, 64'h0,  8'h0,  0, 0,   0, 64'h0,  8'h0,  1, 0, 0);
        vecs[1]  = mkVec(1, 1, 64'h11, 8'h01, 1, 0,   1, 64'h11, 8'h01, 1, 0, 0);
        vecs[2]  = mkVec(1, 1, 64'h22, 8'h02, 1, 0,   1, 64'h22, 8'h02, 1, 0, 0);
        vecs[3]  = mkVec(1, 1, 64'h33, 8'h03, 1, 0,   1, 64'h33, 8'h03, 1, 0, 0);
        vecs[4]  = mkVec(1, 0, 64'h0,  8'h0,  1, 0,   0, 64'h0,  8'h0,  1, 0, 0);
        // Backpressure: A, B taken, C held off, then everything drains in order.
        vecs[5]  = mkVec(1, 1, 64'h44, 8'h04, 0, 0,   1, 64'h44, 8'h04, 1, 0, 0);
        vecs[6]  = mkVec(1, 1, 64'h55, 8'h05, 0, 0,   1, 64'h44, 8'h04, 0, 1, 0);
        vecs[7]  = mkVec(1, 1, 64'h66, 8'h06, 0, 0,   1, 64'h44, 8'h04, 0, 2, 0);
        vecs[8]  = mkVec(1, 1, 64'h66, 8'h06, 0, 0,   1, 64'h44, 8'h04, 0, 3, 0);
        vecs[9]  = mkVec(1, 1, 64'h66, 8'h06, 1, 0,   1, 64'h55, 8'h05, 1, 3, 0);
        vecs[10] = mkVec(1, 1, 64'h66, 8'h06, 1, 0,   1, 64'h66, 8'h06, 1, 3, 0);
        vecs[11] = mkVec(1, 0, 64'h0,  8'h0,  1, 0,   0, 64'h0,  8'h0,  1, 3, 0);
        // Flush while FULL with an offered entry, then flush while EMPTY
        // (not counted), then flush while ONE.
        vecs[12] = mkVec(1, 1, 64'h77, 8'h07, 0, 0,   1, 64'h77, 8'h07, 1, 3, 0);
        vecs[13] = mkVec(1, 1, 64'h88, 8'h08, 0, 0,   1, 64'h77, 8'h07, 0, 4, 0);
        vecs[14] = mkVec(1, 1, 64'h99, 8'h09, 1, 1,   0, 64'h0,  8'h0,  1, 4, 1);
        vecs[15] = mkVec(1, 0, 64'h0,  8'h0,  1, 1,   0, 64'h0,  8'h0,  1, 4, 1);
        vecs[16] = mkVec(1, 0, 64'h0,  8'h0,  1, 0,   0, 64'h0,  8'h0,  1, 4, 1);
        vecs[17] = mkVec(1, 1, 64'hAA, 8'h0A, 0, 0,   1, 64'hAA, 8'h0A, 1, 4, 1);
        vecs[18] = mkVec(1, 1, 64'hBB, 8'h0B, 1, 1,   0, 64'h0,  8'h0,  1, 4, 2);
        vecs[19] = mkVec(1, 0, 64'h0,  8'h0,  1, 0,   0, 64'h0,  8'h0,  1, 4, 2);
        // Reset while FULL, with flush and transfers asserted in the same cycle.
        vecs[20] = mkVec(1, 1, 64'h12, 8'h12, 0, 0,   1, 64'h12, 8'h12, 1, 4, 2);
        vecs[21] = mkVec(1, 1, 64'h34, 8'h34, 0, 0,   1, 64'h12, 8'h12, 0, 5, 2);
        vecs[22] = mkVec(0, 1, 64'h56, 8'h56, 1, 1,   0, 64'h0,  8'h0,  1, 0, 0);
        vecs[23] = mkVec(1, 0, 64'h0,  8'h0,  1, 0,   0, 64'h0,  8'h0,  1, 0, 0);
        vecs[24] = mkVec(1, 0, 64'h0,  8'h0,  1, 0,   0, 64'h0,  8'h0,  1, 0, 0);

        for (int i = 0; i < NumVecs; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].inValid, vecs[i].inData,
                          vecs[i].inCtrl, vecs[i].outReady, vecs[i].flush);
            checkOutput($sformatf("v%0d out_valid", i), {63'b0, outValid}, {63'b0, vecs[i].expValid});
            checkOutput($sformatf("v%0d out_data", i), outData, vecs[i].expData);
            checkOutput($sformatf("v%0d out_ctrl", i), {56'b0, outCtrl}, {56'b0, vecs[i].expCtrl});
            checkOutput($sformatf("v%0d in_ready", i), {63'b0, inReady}, {63'b0, vecs[i].expInReady});
            checkOutput($sformatf("v%0d stall_cnt", i), {48'b0, stallCnt}, {48'b0, vecs[i].expStall});
            checkOutput($sformatf("v%0d flush_cnt", i), {48'b0, flushCnt}, {48'b0, vecs[i].expFlush});
        end

        // Saturation: reset both instances, load one entry, then stall it.
        applyStimulus(0, 0, 64'h0, 8'h0, 0, 0);
        checkOutput("sat reset stall", {60'b0, stallCntS}, 64'd0);
        applyStimulus(1, 1, 64'h5A, 8'h5A, 0, 0);
        checkOutput("sat loaded valid", {63'b0, outValidS}, 64'd1);
        for (int i = 0; i < 14; i++) applyStimulus(1, 0, 64'h0, 8'h0, 0, 0);
        checkOutput("sat stall@14 narrow", {60'b0, stallCntS}, 64'd14);
        checkOutput("sat stall@14 wide", {48'b0, stallCnt}, 64'd14);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 64'h0, 8'h0, 0, 0);
        checkOutput("sat stall@20 narrow", {60'b0, stallCntS}, 64'd15);
        checkOutput("sat stall@20 wide", {48'b0, stallCnt}, 64'd20);
        checkOutput("sat head data", outDataS, 64'h5A);

        // Fill to FULL, then confirm that in_ready ignores out_ready
        // combinationally.
        applyStimulus(1, 1, 64'h6B, 8'h6B, 0, 0);
        checkOutput("full in_ready", {63'b0, inReady}, 64'd0);
        inValid  = 1'b0;
        outReady = 1'b1;
        #1;
        checkOutput("full in_ready w/ out_ready", {63'b0, inReady}, 64'd0);
        applyStimulus(1, 0, 64'h0, 8'h0, 1, 0);
        checkOutput("skid to head data", outData, 64'h6B);
        checkOutput("skid to head ctrl", {56'b0, outCtrl}, 64'h6B);
        applyStimulus(1, 0, 64'h0, 8'h0, 1, 0);
        checkOutput("drained valid", {63'b0, outValid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
